// File: rtl/calc_key_arbiter.sv
// Key arbiter: merges keypad strobes and host bytes into a paced key stream.
// Optional character filter enabled by defining CALC_KEY_FILTER_EN.
module calc_key_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pnl_valid,
  input  logic [7:0]                    pnl_char,
  input  logic                          host_valid,
  input  logic [7:0]                    host_char,
  output logic                          host_ready,
  input  logic                          sink_busy,
  output logic                          key_valid,
  output logic [7:0]                    key_char,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t          state;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            pnl_ok;
  logic            host_ok;
  logic            host_acc;
  logic            push;
  logic            pop;
  logic            drop;
  logic [7:0]      push_char;
  logic            issue_go;

`ifdef CALC_KEY_FILTER_EN
  function automatic logic key_legal(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           c == 8'h2A || c == 8'h2B ||
           c == 8'h2D || c == 8'h2F ||
           c == 8'h3D || c == 8'h43;
  endfunction
  assign pnl_ok  = key_legal(pnl_char);
  assign host_ok = key_legal(host_char);
`else
  assign pnl_ok  = 1'b1;
  assign host_ok = 1'b1;
`endif

  // Full/empty come from the level at the start of the cycle.
  assign full       = fifo_level == LW'(FIFO_DEPTH);
  assign empty      = fifo_level == '0;
  assign host_ready = !rst && !full && !pnl_valid;
  assign host_acc   = host_valid && host_ready;
  assign pop        = state == ISSUE;
  assign issue_go   = !empty && !sink_busy;

  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    push_char = pnl_char;
    if (pnl_valid) begin
      if (full || !pnl_ok) drop = 1'b1;
      else push = 1'b1;
    end else if (host_acc) begin
      push_char = host_char;
      if (host_ok) push = 1'b1;
      else drop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      key_valid <= 1'b0;
      key_char  <= 8'h00;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue_go) begin
            state     <= ISSUE;
            key_valid <= 1'b1;
            key_char  <= mem[rd_ptr];
          end
        end
        ISSUE: begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            if (issue_go) begin
              state     <= ISSUE;
              key_valid <= 1'b1;
              key_char  <= mem[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_key_arbiter.sv
// Scoreboard bench for calc_key_arbiter: ordering, pacing, overflow, reset.
// Filter expectations follow CALC_KEY_FILTER_EN.
module tb_calc_key_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pnl_valid = 1'b0;
  logic [7:0] pnl_char = 8'h00;
  logic       host_valid = 1'b0;
  logic [7:0] host_char = 8'h00;
  logic       host_ready;
  logic       sink_busy = 1'b0;
  logic       key_valid;
  logic [7:0] key_char;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int stamps[$];
  logic [7:0] exp_c;

  calc_key_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .pnl_valid(pnl_valid), .pnl_char(pnl_char),
    .host_valid(host_valid), .host_char(host_char),
    .host_ready(host_ready), .sink_busy(sink_busy),
    .key_valid(key_valid), .key_char(key_char),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && key_valid) begin
      stamps.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected got=%h want=none", key_char);
      end else begin
        exp_c = exp_q.pop_front();
        if (key_char !== exp_c) begin
          bad++;
          $display("FAIL strobe_char got=%h want=%h", key_char, exp_c);
        end
      end
    end
  end

  task automatic wait_stamps(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stamps.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic pnl_key(input logic [7:0] c);
    pnl_valid = 1'b1;
    pnl_char  = c;
    @(posedge clk);
    #1;
    pnl_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (key_valid !== 1'b0) begin
      bad++; $display("FAIL rst_key_valid got=%b want=0", key_valid);
    end
    if (key_char !== 8'h00) begin
      bad++; $display("FAIL rst_key_char got=%h want=00", key_char);
    end
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL rst_level got=%0d want=0", fifo_level);
    end
    if (drop_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_drop got=%0d want=0", drop_cnt);
    end
    if (host_ready !== 1'b0) begin
      bad++; $display("FAIL rst_host_ready got=%b want=0", host_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    int c;
    bit ok;
    stamps.delete();
    @(posedge clk);
    #1;
    c = cyc;
    exp_q.push_back(8'h35);
    pnl_key(8'h35);
    wait_stamps(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_timeout got=0 want=1 strobes");
    end else if (stamps[0] !== c + 2) begin
      bad++; $display("FAIL single_latency got=%0d want=%0d", stamps[0] - c, 2);
    end
    idle(2);
    total++;
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL single_level got=%0d want=0", fifo_level);
    end
    idle(8);
  endtask

  task automatic test_host_burst;
    logic [7:0] seq [3];
    bit ok;
    int guard;
    seq[0] = 8'h31; seq[1] = 8'h32; seq[2] = 8'h2B;
    stamps.delete();
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1;
      host_char  = seq[i];
      guard = 0;
      while (!host_ready && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      exp_q.push_back(seq[i]);
      @(posedge clk);
      #1;
    end
    host_valid = 1'b0;
    wait_stamps(3, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL burst_timeout got=%0d want=3 strobes", stamps.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (stamps[i] - stamps[i-1] !== 5) begin
          bad++;
          $display("FAIL burst_spacing got=%0d want=5", stamps[i] - stamps[i-1]);
        end
      end
    end
    idle(10);
  endtask

  task automatic test_overflow;
    bit ok;
    stamps.delete();
    sink_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(8'h30 + 8'(i));
      pnl_key(8'h30 + 8'(i));
    end
    @(negedge clk);
    total += 3;
    if (fifo_level !== 3'd4) begin
      bad++; $display("FAIL ovf_level got=%0d want=4", fifo_level);
    end
    if (drop_cnt !== 8'd2) begin
      bad++; $display("FAIL ovf_drop got=%0d want=2", drop_cnt);
    end
    if (stamps.size() !== 0) begin
      bad++; $display("FAIL ovf_busy_hold got=%0d want=0 strobes", stamps.size());
    end
    sink_busy = 1'b0;
    wait_stamps(4, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL ovf_timeout got=%0d want=4 strobes", stamps.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (stamps[i] - stamps[i-1] !== 5) begin
          bad++;
          $display("FAIL ovf_spacing got=%0d want=5", stamps[i] - stamps[i-1]);
        end
      end
    end
    idle(10);
    total++;
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL ovf_drain got=%0d want=0", fifo_level);
    end
  endtask

  task automatic test_contention;
    bit ok;
    int c;
    stamps.delete();
    @(posedge clk);
    #1;
    c = cyc;
    pnl_valid  = 1'b1;
    pnl_char   = 8'h37;
    host_valid = 1'b1;
    host_char  = 8'h38;
    exp_q.push_back(8'h37);
    exp_q.push_back(8'h38);
    #1;
    total++;
    if (host_ready !== 1'b0) begin
      bad++; $display("FAIL cont_ready_blocked got=%b want=0", host_ready);
    end
    @(posedge clk);
    #1;
    pnl_valid = 1'b0;
    #1;
    total++;
    if (host_ready !== 1'b1) begin
      bad++; $display("FAIL cont_ready_next got=%b want=1", host_ready);
    end
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    wait_stamps(2, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL cont_timeout got=%0d want=2 strobes", stamps.size());
    end else if (stamps[0] !== c + 2 || stamps[1] !== c + 7) begin
      bad++;
      $display("FAIL cont_timing got=%0d,%0d want=%0d,%0d",
               stamps[0], stamps[1], c + 2, c + 7);
    end
    idle(10);
  endtask

  task automatic test_filter;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stamps.delete();
    @(posedge clk);
    #1;
    host_valid = 1'b1;
    host_char  = 8'h41;
    #1;
    total++;
    if (host_ready !== 1'b1) begin
      bad++; $display("FAIL filt_ready got=%b want=1", host_ready);
    end
`ifndef CALC_KEY_FILTER_EN
    exp_q.push_back(8'h41);
`endif
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    idle(12);
    total += 2;
`ifdef CALC_KEY_FILTER_EN
    if (stamps.size() !== 0) begin
      bad++; $display("FAIL filt_strobes got=%0d want=0", stamps.size());
    end
    if (drop_cnt !== 8'd1) begin
      bad++; $display("FAIL filt_drop got=%0d want=1", drop_cnt);
    end
`else
    if (stamps.size() !== 1) begin
      bad++; $display("FAIL filt_strobes got=%0d want=1", stamps.size());
    end
    if (drop_cnt !== 8'd0) begin
      bad++; $display("FAIL filt_drop got=%0d want=0", drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_gap;
    bit ok;
    int c;
    stamps.delete();
    @(posedge clk);
    #1;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h33);
    pnl_key(8'h31);
    pnl_key(8'h32);
    pnl_key(8'h33);
    wait_stamps(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rgap_timeout got=0 want=1 strobes");
    end
    @(posedge clk);
    #2;
    total++;
    if (fifo_level !== 3'd2) begin
      bad++; $display("FAIL rgap_level_before got=%0d want=2", fifo_level);
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    total += 4;
    if (key_valid !== 1'b0) begin
      bad++; $display("FAIL rgap_key_valid got=%b want=0", key_valid);
    end
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL rgap_level got=%0d want=0", fifo_level);
    end
    if (key_char !== 8'h00) begin
      bad++; $display("FAIL rgap_key_char got=%h want=00", key_char);
    end
    if (host_ready !== 1'b0) begin
      bad++; $display("FAIL rgap_host_ready got=%b want=0", host_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    stamps.delete();
    @(posedge clk);
    #1;
    c = cyc;
    exp_q.push_back(8'h39);
    pnl_key(8'h39);
    wait_stamps(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rgap_new_timeout got=0 want=1 strobes");
    end else if (stamps[0] !== c + 2) begin
      bad++; $display("FAIL rgap_new_latency got=%0d want=2", stamps[0] - c);
    end
    idle(10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_host_burst();
    test_overflow();
    test_contention();
    test_filter();
    test_reset_mid_gap();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_key_arbiter.md
# calc_key_arbiter

Key-event arbiter and pacer between the key sources and the calculator FSM. It merges two character sources into one ordered key stream: the on-screen keypad's single-cycle strobe and a host byte stream with a valid/ready handshake. Keys are buffered in a small FIFO and issued to the calculator as single-cycle `key_valid` strobes, with a guaranteed idle gap between strobes. Issue is held off while the calculator reports busy. The block sits in `lcd_top` between the keypad/host inputs and the calculator FSM's `btn_valid`/`btn_char` inputs.

## Interface
- `FIFO_DEPTH`, 4: key buffer entries; power of two, ≥2.
- `GAP_CYCLES`, 4: minimum idle cycles after each output strobe; ≥1.
- `clk` in 1: 33 MHz LCD-domain clock; sole clock.
- `rst` in 1: asynchronous reset, active-high.
- `pnl_valid` in 1: keypad strobe, one cycle per key; cannot be stalled.
- `pnl_char` in 8: ASCII key code, qualified by `pnl_valid`.
- `host_valid` in 1: host byte offered; held until accepted.
- `host_char` in 8: ASCII byte, stable while `host_valid` is high.
- `host_ready` out 1: host byte accepted on any edge where `host_valid && host_ready`.
- `sink_busy` in 1: calculator busy; no new issue decision while high.
- `key_valid` out 1: single-cycle key strobe to the calculator FSM.
- `key_char` out 8: key code; valid only while `key_valid` is high.
- `fifo_level` out log2(FIFO_DEPTH)+1: current FIFO occupancy.
- `drop_cnt` out 8: count of discarded keys; saturates at 255.

## Operation
- **Write arbitration** (at most one FIFO write per cycle):
  - The keypad has fixed priority.
  - `host_ready = !rst && fifo_level < FIFO_DEPTH && !pnl_valid`. This is combinational.
- **Keypad strobe with the FIFO full:** the key is dropped and `drop_cnt` increments.
- **Full check:** uses the level at the start of the cycle. A push while full is rejected even if a pop occurs in the same cycle.
- **Ordering:** output order equals acceptance order.
- **Issue FSM:**
  - IDLE: go to ISSUE if the FIFO is not empty and `sink_busy` is low; otherwise stay.
  - ISSUE (one cycle): `key_valid`=1 and `key_char`=FIFO head. Pop at the end of the cycle, then go to GAP.
  - GAP: count `GAP_CYCLES` cycles. In the last GAP cycle, apply the IDLE condition: go to ISSUE if it holds, otherwise go to IDLE.
- **`sink_busy`** is sampled only at issue decisions. Once in ISSUE, the strobe completes regardless of `sink_busy`.
- **`drop_cnt`** increments by at most 1 per cycle, because the host is never accepted in the same cycle as a keypad key. It saturates at 255 and clears only on reset.

## Timing
- **Reset values:** `key_valid`=0, `key_char`=0x00, `fifo_level`=0, `drop_cnt`=0, `host_ready`=0, FSM in IDLE, FIFO pointers cleared.
- **Reset mid-operation:** all queued keys are discarded, and any in-progress strobe or gap is aborted immediately.
- **Latency:** an input accepted in cycle C gives `key_valid` high in cycle C+2, provided the FSM is IDLE, the FIFO was empty and `sink_busy` is low.
- **Strobe spacing:** back-to-back queued keys give strobes exactly `GAP_CYCLES`+1 cycles apart.
- **`fifo_level` update:** changes on the edge after a push or pop. A push and pop in the same cycle leave the level unchanged.
- **Outputs:** `key_valid`, `key_char`, `fifo_level` and `drop_cnt` are registered. `host_ready` is the only combinational output.

## Configuration
- **`CALC_KEY_FILTER_EN` defined:**
  - Only legal characters are written: 0x30–0x39, 0x2A `*`, 0x2B `+`, 0x2D `-`, 0x2F `/`, 0x3D `=`, 0x43 `C`.
  - An illegal character is discarded and `drop_cnt` increments.
  - A host handshake still completes for an illegal byte; `host_ready` is unaffected by the filter.
- **Not defined:** every character is queued unchanged, and `drop_cnt` counts only keypad overflow drops.

## Test plan
- **Single keypad key:** `pnl_char`=0x35 strobed in cycle C, idle block → `key_valid` high only in C+2 with `key_char`=0x35; `fifo_level` returns to 0.
- **Host burst pacing:** host sends 0x31, 0x32, 0x2B back-to-back with `GAP_CYCLES`=4 → three strobes 5 cycles apart, in order 0x31, 0x32, 0x2B.
- **Overflow:** `sink_busy`=1, six keypad keys 0x30–0x35 → `fifo_level`=4, `drop_cnt`=2. Releasing `sink_busy` → 0x30–0x33 issued in order.
- **Contention:** `pnl_valid` and `host_valid` high in the same cycle (0x37 / 0x38) → `host_ready`=0 that cycle and the host byte is accepted next cycle; output order 0x37, 0x38.
- **Filter:** host sends 0x41.
  - With the macro → no strobe, `drop_cnt`=1, handshake completes.
  - Without the macro → `key_char`=0x41.
- **Reset mid-gap:** `rst` asserted during GAP with 2 keys queued → all outputs at reset values immediately. A new key after release issues with 2-cycle latency.
